mips32_fetch_queue: RTL and testbench
=====================================

// Module: mips32_fetch_queue
// PURPOSE
//   Instruction-fetch front end for the pipe_MIPS32 core. Issues word reads to instruction memory,
//   buffers the returned words with their next-PC in a small prefetch queue, and presents them to the
//   IF/ID register with a valid/ready handshake. Handles branch redirects (queue flush) and stops
//   fetching after a HLT instruction (opcode 6'h3f).
// PARAMETERS
//   DEPTH     4        prefetch queue entries; power of two, >= 2
//   PC_W      32       PC width; PC is word-addressed, NPC = PC + 1
//   RESET_PC  32'h0    first fetch address after reset
// PORTS
//   clk              in   1     single clock, rising edge
//   rst_n            in   1     asynchronous, active-low reset
//   imem_req         out  1     read request; held until imem_ack
//   imem_addr        out  PC_W  word address; stable while imem_req=1
//   imem_ack         in   1     read data valid this cycle; any latency >= 1 cycle
//   imem_rdata       in   32    instruction word, valid with imem_ack
//   id_valid         out  1     queue head valid toward IF/ID
//   id_ready         in   1     IF/ID accepts head this cycle
//   id_ir            out  32    head instruction
//   id_npc           out  PC_W  head next-PC (fetch address + 1)
//   redirect_valid   in   1     taken branch from EX/MEM; flush and restart
//   redirect_pc      in   PC_W  restart address
//   halted           out  1     HLT has been queued; fetch stopped
//   occupancy        out  clog2(DEPTH)+1  entries currently in queue
// BEHAVIOUR
//   - Reset (async, rst_n=0): imem_req=0, imem_addr=RESET_PC, id_valid=0, halted=0, occupancy=0,
//     drop flag cleared. First imem_req rises on the first clk edge after rst_n deasserts.
//   - At most one outstanding request. New request issued only when !halted, no request outstanding,
//     and occupancy + outstanding < DEPTH (a slot is always reserved for the returning word).
//   - On imem_ack (not dropped): push {imem_rdata, fetch_pc+1}; fetch_pc <= fetch_pc+1 (wraps mod 2^PC_W);
//     imem_req drops same edge, may re-rise the following edge (back-to-back: 1 word / 2 cycles at
//     1-cycle memory latency).
//   - Latency: imem_ack at edge N -> id_valid=1 with that word after edge N (registered queue, head
//     combinational from storage).
//   - Pop on id_valid && id_ready. Push and pop in the same cycle: occupancy unchanged.
//   - Full: no request issued; never overflows. Empty: id_valid=0, id_ir/id_npc don't-care.
//   - HLT: pushed word with [31:26]==6'h3f sets halted; no further requests. HLT itself is delivered to ID.
//   - Redirect (registered in one edge): queue emptied, fetch_pc <= redirect_pc, halted <= 0.
//     If a request is outstanding, imem_req/imem_addr stay held until ack and that data is discarded
//     (drop flag); the redirected fetch issues on the edge after that ack.
//   - Redirect same cycle as ack: redirect wins, data discarded. Redirect same cycle as pop: pop
//     accepted by ID, queue still flushed. Redirect while halted: resumes fetching.
//   - Reset mid-operation: all state to reset values immediately; late imem_ack after reset ignored.
// STRUCTURE
//   - mips32_pkg: OP_HLT = 6'h3f, OPCODE_MSB/LSB = 31/26, instruction word width 32, NOP word
//     32'h0ce77800 (used by benches as filler).
//   - Sub-module mips32_sync_fifo (DEPTH x (32+PC_W), push/pop/flush, count, full/empty); fetch
//     control FSM (IDLE, WAIT_ACK, WAIT_DROP, HALT) in this module.
// TESTING
//   1 Reset, imem 1-cycle latency, Mem[0..2]=28_01_000a/28020014/28030019, id_ready=1 -> ID sees
//     three words in order, id_npc=1,2,3; imem_addr 0,1,2.
//   2 id_ready=0, DEPTH=4 -> exactly 4 acks then imem_req stays 0, occupancy=4; release ready ->
//     fetch resumes at PC 4, no word lost or duplicated.
//   3 Mem[3]=32'hfc000000 -> halted=1 after its push, no request for addr 4, HLT delivered with npc=4.
//   4 redirect_valid with redirect_pc=0x20 while request to 5 outstanding (3-cycle latency) ->
//     word@5 discarded, queue empty, next imem_addr=0x20.
//   5 redirect and imem_ack same cycle; redirect while halted -> data dropped; fetch restarts,
//     halted=0.
//   6 rst_n pulsed low mid-fetch with queue half full -> occupancy=0, id_valid=0, imem_addr=RESET_PC
//     asynchronously.

Source files
------------

// File: rtl/mips32_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// mips32_pkg : shared encodings for the pipe_MIPS32 fetch front end
// rev 1.0
//------------------------------------------------------------------
package mips32_pkg;

  localparam int               INSTR_W    = 32;
  localparam int               OPCODE_MSB = 31;
  localparam int               OPCODE_LSB = 26;
  localparam logic [5:0]       OP_HLT     = 6'h3f;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0ce77800;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] ir);
    return ir[OPCODE_MSB:OPCODE_LSB] == OP_HLT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips32_sync_fifo.sv
`default_nettype none
//------------------------------------------------------------------
// mips32_sync_fifo : power-of-two synchronous FIFO with flush
// rev 1.0
//------------------------------------------------------------------
module mips32_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  // Flush takes priority over any push or pop in the same cycle.
  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mips32_fetch_queue.sv
`default_nettype none
//------------------------------------------------------------------
// mips32_fetch_queue : imem fetch control + prefetch queue toward IF/ID
// rev 1.0
//------------------------------------------------------------------
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_o,
  output logic [PC_W-1:0]        imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_W-1:0]     imem_rdata_i,
  output logic                   id_valid_o,
  input  logic                   id_ready_i,
  output logic [INSTR_W-1:0]     id_ir_o,
  output logic [PC_W-1:0]        id_npc_o,
  input  logic                   redirect_valid_i,
  input  logic [PC_W-1:0]        redirect_pc_i,
  output logic                   halted_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT_DROP = 2'd2;
  localparam logic [1:0] S_HALT      = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [PC_W-1:0]         fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]         req_addr_q, req_addr_d;
  logic [PC_W-1:0]         ack_npc;
  logic                    push, flush, full, empty;
  logic [INSTR_W+PC_W-1:0] head;

  assign ack_npc = req_addr_q + PC_W'(1);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    flush      = redirect_valid_i;
    if (redirect_valid_i) fetch_pc_d = redirect_pc_i;
    case (state_q)
      // Only issue with nothing outstanding and a free slot for the returning word.
      S_IDLE: begin
        if (!redirect_valid_i && !full) begin
          state_d    = S_WAIT_ACK;
          req_addr_d = fetch_pc_q;
        end
      end
      S_WAIT_ACK: begin
        if (imem_ack_i) begin
          if (redirect_valid_i) begin
            state_d = S_IDLE;
          end else begin
            push       = 1'b1;
            fetch_pc_d = ack_npc;
            state_d    = is_hlt(imem_rdata_i) ? S_HALT : S_IDLE;
          end
        end else if (redirect_valid_i) begin
          state_d = S_WAIT_DROP;
        end
      end
      // Request stays held until its ack; the returning data is stale.
      S_WAIT_DROP: begin
        if (imem_ack_i) state_d = S_IDLE;
      end
      S_HALT: begin
        if (redirect_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  mips32_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + PC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({imem_rdata_i, ack_npc}),
    .pop_i   (id_valid_o && id_ready_i),
    .flush_i (flush),
    .data_o  (head),
    .count_o (occupancy_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign imem_req_o  = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DROP);
  assign imem_addr_o = req_addr_q;
  assign halted_o    = state_q == S_HALT;
  assign id_valid_o  = !empty;
  assign id_ir_o     = head[INSTR_W+PC_W-1:PC_W];
  assign id_npc_o    = head[PC_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_queue.sv
`default_nettype none
// tb_mips32_fetch_queue : scoreboard bench with a variable-latency imem model
module tb_mips32_fetch_queue;
  import mips32_pkg::*;

  localparam logic [31:0] HLT_WORD = 32'hfc000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_ir, id_npc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;
  logic [2:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int cnt     = 0;
  int ack_cnt = 0;
  logic [31:0] mem [0:127];
  logic [31:0] addr_log[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mips32_fetch_queue #(.DEPTH(4), .PC_W(32), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .id_valid_o       (id_valid),
    .id_ready_i       (id_ready),
    .id_ir_o          (id_ir),
    .id_npc_o         (id_npc),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .halted_o         (halted),
    .occupancy_o      (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory: ack after lat cycles of request, one-cycle ack pulse.
  always @(posedge clk) begin
    #1;
    if (!rst_n || imem_ack) begin
      imem_ack = 1'b0;
      cnt = 0;
    end else if (imem_req) begin
      if (cnt == 0) addr_log.push_back(imem_addr);
      cnt++;
      if (cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr[6:0]];
        ack_cnt++;
      end
    end
  end

  // ID side: every accepted head must match the next expected {ir, npc}.
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready) begin
      check("sb_expect", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("id_word", {id_ir, id_npc}, exp_q.pop_front());
    end
  end

  task automatic put(input int a, input logic [31:0] w);
    mem[a[6:0]] = w;
    exp_q.push_back({w, 32'(a + 1)});
  endtask

  task automatic start(input int latency, input logic ready);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = ready;
    lat = latency;
    exp_q.delete();
    addr_log.delete();
    ack_cnt = 0;
    for (int i = 0; i < 128; i++) mem[i] = NOP_WORD;
  endtask

  task automatic release_rst();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (halted && exp_q.size() == 0 && !id_valid) break;
      @(posedge clk); #2;
    end
    check({tag, "_done"}, 64'({halted, exp_q.size() == 0, id_valid}), 64'(3'b110));
  endtask

  task automatic wait_req_addr(input string tag, input logic [31:0] a);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (imem_req && imem_addr == a) break;
    end
    check(tag, 64'({imem_req, imem_addr}), 64'({1'b1, a}));
  endtask

  task automatic check_addr(input string tag, input int idx, input logic [31:0] a);
    logic [31:0] got;
    got = (idx < addr_log.size()) ? addr_log[idx] : 32'hffff_ffff;
    check(tag, 64'(got), 64'(a));
  endtask

  initial begin
    #1;
    // Reset state, in-order delivery at 1-cycle latency, then HLT
    start(1, 1'b1);
    #1;
    check("rst_req",   64'(imem_req),  64'd0);
    check("rst_addr",  64'(imem_addr), 64'd0);
    check("rst_valid", 64'(id_valid),  64'd0);
    check("rst_halt",  64'(halted),    64'd0);
    check("rst_occ",   64'(occupancy), 64'd0);
    put(0, 32'h2801000a);
    put(1, 32'h28020014);
    put(2, 32'h28030019);
    put(3, HLT_WORD);
    release_rst();
    @(posedge clk); #2;
    check("t1_first_req", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0}));
    wait_done("t1");
    idle(4);
    check("t1_req_off", 64'(imem_req), 64'd0);
    check("t1_nreq", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_addr("t1_addr", i, 32'(i));

    // Back-pressure: queue fills to DEPTH, fetch stalls, resumes at PC 4
    start(1, 1'b0);
    for (int i = 0; i < 7; i++) put(i, 32'h20000000 | 32'(i));
    put(7, HLT_WORD);
    release_rst();
    idle(30);
    check("t2_occ_full", 64'(occupancy), 64'd4);
    check("t2_req_off",  64'(imem_req),  64'd0);
    check("t2_acks",     64'(ack_cnt),   64'd4);
    check("t2_valid",    64'(id_valid),  64'd1);
    id_ready = 1'b1;
    wait_done("t2");
    check("t2_nreq", 64'(addr_log.size()), 64'd8);
    check_addr("t2_resume", 4, 32'd4);

    // Redirect with a 3-cycle request outstanding: data dropped, addr held
    start(3, 1'b1);
    for (int i = 0; i < 5; i++) put(i, 32'h20000000 | 32'(i));
    mem[5] = 32'h20000005;
    release_rst();
    wait_req_addr("t4_req5", 32'd5);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    put(32'h20, 32'h24000020);
    put(32'h21, 32'h24000021);
    put(32'h22, HLT_WORD);
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    check("t4_occ",   64'(occupancy), 64'd0);
    check("t4_valid", 64'(id_valid),  64'd0);
    check("t4_held",  64'({imem_req, imem_addr}), 64'({1'b1, 32'd5}));
    wait_done("t4");
    check("t4_nreq", 64'(addr_log.size()), 64'd9);
    check_addr("t4_new_addr", 6, 32'h20);

    // Redirect coinciding with ack; then redirect while halted
    start(2, 1'b1);
    put(0, 32'h20000000);
    put(1, 32'h20000001);
    mem[2] = 32'h20000002;
    release_rst();
    wait_req_addr("t5_req2", 32'd2);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #2;
    check("t5_ack_now", 64'(imem_ack), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h30;
    put(32'h30, HLT_WORD);
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    check("t5_req_off", 64'(imem_req),  64'd0);
    check("t5_occ",     64'(occupancy), 64'd0);
    wait_done("t5a");
    check_addr("t5_addr30", 3, 32'h30);
    put(32'h40, 32'h24000040);
    put(32'h41, HLT_WORD);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    check("t5_unhalt", 64'(halted), 64'd0);
    wait_done("t5b");
    check("t5_nreq", 64'(addr_log.size()), 64'd6);
    check_addr("t5_addr40", 4, 32'h40);

    // Asynchronous reset mid-fetch with the queue half full
    start(1, 1'b0);
    for (int i = 0; i < 5; i++) mem[i] = 32'h20000000 | 32'(i);
    mem[5] = HLT_WORD;
    release_rst();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (occupancy == 3'd2) break;
    end
    check("t6_half", 64'(occupancy), 64'd2);
    @(posedge clk); #2;
    check("t6_midfetch", 64'({imem_req, imem_addr}), 64'({1'b1, 32'd2}));
    #3;
    rst_n = 1'b0;
    addr_log.delete();
    exp_q.delete();
    #1;
    check("t6_occ",   64'(occupancy), 64'd0);
    check("t6_valid", 64'(id_valid),  64'd0);
    check("t6_addr",  64'(imem_addr), 64'd0);
    check("t6_req",   64'(imem_req),  64'd0);
    check("t6_halt",  64'(halted),    64'd0);
    #1;
    rst_n = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back({mem[i], 32'(i + 1)});
    wait_done("t6");
    check("t6_nreq", 64'(addr_log.size()), 64'd6);
    check_addr("t6_restart", 0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
